mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single memory port between the instruction-fetch requester (m1) and the execute stage's load/store requester (m0), and sequences sub-word stores as read-modify-write so the execute stage never merges bytes itself. Sits between `ex`/fetch and the unified memory. It carries one outstanding transaction at a time and returns aligned read data and a pipeline hold.

## Interface
- `TIMEOUT`, 16: cycles `s_req` may stay high without `s_ack` before the transaction is aborted with an error.
- `STARVE_LIMIT`, 4: maximum consecutive m0 grants while `m1_req` is pending.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `m0_req` in 1: execute-stage request.
- `m0_we` in 1: 1 = store, 0 = load.
- `m0_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `m0_addr` in 32: byte address.
- `m0_wdata` in 32: store data, right-aligned.
- `m0_rdata` out 32: load data shifted right by `8*m0_addr[1:0]`.
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_err` out 1: valid with `m0_ack`; flags a misaligned access, illegal size, or timeout.
- `m1_req` in 1: fetch request; always a word read.
- `m1_addr` in 32: fetch address.
- `m1_rdata` out 32: fetched word.
- `m1_ack` out 1: one-cycle completion pulse.
- `m1_err` out 1: valid with `m1_ack`; flags misalignment or timeout.
- `s_req` out 1: memory request, held until `s_ack`.
- `s_we` out 1: memory write enable.
- `s_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `s_wdata` out 32: write word.
- `s_rdata` in 32: read word, valid with `s_ack`.
- `s_ack` in 1: memory completion; may assert in the same cycle `s_req` first rises.
- `hold_o` out 1: combinational `m0_req & ~m0_ack`; stalls the pipeline.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- In IDLE, requests are sampled on each edge.
  - m0 wins by default.
  - m1 wins if `m1_req` is pending and the consecutive-m0 grant counter equals `STARVE_LIMIT`.
  - A grant to m1, or an IDLE cycle with `m1_req` low, clears the counter.
  - Each m0 grant increments the counter, saturating at `STARVE_LIMIT`.
- Alignment check at grant; a failing request goes straight to RESP with err=1 and no memory access. Failing cases:
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` != 0;
  - `m0_size` = 3;
  - m1 with `addr[1:0]` != 0.
- Next state after grant:
  - RD for m0 loads and all m1 fetches.
  - WR for word stores; `s_wdata` = `m0_wdata`.
  - RMW_RD for byte and half stores.
- RMW merge, on `s_ack` in RMW_RD: the read word is registered, and the lanes selected by `addr[1:0]` are replaced with `m0_wdata[7:0]` (byte) or `m0_wdata[15:0]` (half). Then RMW_RD -> RMW_WR.
- `s_req`, `s_we`, `s_addr`, `s_wdata` are registered and stay stable from the state's first cycle until `s_ack`.
  - In RMW, `s_req` deasserts for exactly one cycle between the read and the write.
- RD/WR/RMW_WR -> RESP on `s_ack`. RESP drives the granted master's ack for one cycle, then goes to IDLE.
  - `m0_rdata`/`m1_rdata` are registered, and hold their last value otherwise.
  - Store acks return `m0_rdata` unchanged.
- Timeout: a counter resets on entry to each bus state. If it reaches `TIMEOUT` without `s_ack`, `s_req` drops and the block goes to RESP with err=1. An RMW aborted in RMW_RD performs no write.
- A master must hold req/addr/data stable until its ack. Deasserting req mid-transaction does not cancel it; the ack is still issued.
- A requester may re-request in the cycle after its ack; it is sampled in IDLE the following cycle.

## Timing
- Reset values: all outputs 0 (`hold_o` follows `m0_req`), state IDLE, counters 0.
- Reset asserted mid-transaction drops `s_req` immediately; no ack is issued.
- Latency, edge 0 = the IDLE grant edge:
  - Read or word write with zero-wait `s_ack`: `s_req` in cycle 1, ack in cycle 2.
  - Add one cycle per memory wait state.
  - RMW with zero-wait memory: read in cycle 1, idle gap in cycle 2, write in cycle 3, ack in cycle 4.
  - Misaligned: ack with err in cycle 1.
- Simultaneous `m0_req` and `m1_req` with the counter below limit: m0 is served first, and m1 is granted in the IDLE cycle following the m0 ack.
- `s_ack` outside a bus state is ignored.

## Test plan
- Fetch only: `m1_addr`=0x100, memory returns 0x00500093 with zero wait -> `s_addr`=0x100, `m1_ack` in cycle 2, `m1_rdata`=0x00500093, `m1_err`=0.
- Byte store: `m0_addr`=0x203, size 0, `m0_wdata`=0xAB, memory word 0x11223344 -> read 0x200, then write 0x200 with 0xAB223344, `m0_ack` in cycle 4.
- Half load: `m0_addr`=0x302, memory word 0xDEADBEEF -> `m0_rdata`=0x0000DEAD. Half at 0x301 -> `m0_ack`+`m0_err` in cycle 1, `s_req` never asserts.
- Starvation: `m0_req` held for back-to-back loads with `m1_req` high -> exactly 4 m0 acks, then m1 is granted, then m0 resumes.
- Timeout: `s_ack` tied low on a byte store -> `s_req` drops after 16 cycles, `m0_err`=1, no write ever issued. Reset pulse mid-read -> all outputs 0, IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between fetch (m1) and load/store (m0).
// Sub-word stores are sequenced as read-modify-write so ex never merges bytes.
module mem_arbiter #(
   parameter int TIMEOUT      = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        s_req,
   output logic        s_we,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ack,
   output logic        hold_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE, RD, WR, RMW_RD, RMW_WR, RESP
   } state_t;

   state_t        state, state_n;
   logic          gnt_m1, err_q;
   logic [1:0]    lane_q, size_q;
   logic [15:0]   wdata_q;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] starve;
   logic          any_req, pick_m1, bad;
   logic          bus, done, tmo;
   logic [31:0]   sel_addr, merged;

   always_comb begin
      any_req  = m0_req | m1_req;
      pick_m1  = m1_req & (~m0_req | (starve == SW'(STARVE_LIMIT)));
      sel_addr = pick_m1 ? m1_addr : m0_addr;
      if (pick_m1) begin
         bad = |m1_addr[1:0];
      end else begin
         bad = (m0_size == 2'd3)
             | ((m0_size == 2'd1) & m0_addr[0])
             | ((m0_size == 2'd2) & (|m0_addr[1:0]));
      end
   end

   // RMW_WR is only a bus state once its idle gap cycle is over
   always_comb begin
      bus  = (state == RD) | (state == WR) | (state == RMW_RD)
           | ((state == RMW_WR) & s_req);
      done = bus & s_ack;
      tmo  = bus & ~s_ack & (tcnt == TW'(TIMEOUT - 1));
   end

   always_comb begin
      merged = s_rdata;
      if (size_q == 2'd0) begin
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               if (bad) begin
                  state_n = RESP;
               end else if (pick_m1 | ~m0_we) begin
                  state_n = RD;
               end else if (m0_size == 2'd2) begin
                  state_n = WR;
               end else begin
                  state_n = RMW_RD;
               end
            end
         end
         RD, WR, RMW_WR: begin
            if (done | tmo) state_n = RESP;
         end
         RMW_RD: begin
            if (done) begin
               state_n = RMW_WR;
            end else if (tmo) begin
               state_n = RESP;
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_m1   <= 1'b0;
         err_q    <= 1'b0;
         lane_q   <= '0;
         size_q   <= '0;
         wdata_q  <= '0;
         tcnt     <= '0;
         starve   <= '0;
         s_req    <= 1'b0;
         s_we     <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         if (state == IDLE) begin
            if (!m1_req || pick_m1) begin
               starve <= '0;
            end else if (starve != SW'(STARVE_LIMIT)) begin
               starve <= starve + 1'b1;
            end
            if (any_req) begin
               gnt_m1  <= pick_m1;
               err_q   <= bad;
               lane_q  <= sel_addr[1:0];
               size_q  <= m0_size;
               wdata_q <= m0_wdata[15:0];
               tcnt    <= '0;
               s_req   <= ~bad;
               s_we    <= ~pick_m1 & m0_we & (m0_size == 2'd2);
               s_addr  <= {sel_addr[31:2], 2'b00};
               s_wdata <= m0_wdata;
            end
         end
         if (done) begin
            s_req <= 1'b0;
            tcnt  <= '0;
            if (state == RD && gnt_m1) m1_rdata <= s_rdata;
            if (state == RD && !gnt_m1) begin
               m0_rdata <= s_rdata >> {lane_q, 3'b000};
            end
            if (state == RMW_RD) s_wdata <= merged;
         end else if (tmo) begin
            s_req <= 1'b0;
            err_q <= 1'b1;
         end else if (bus) begin
            tcnt <= tcnt + 1'b1;
         end
         if (state == RMW_WR && !s_req) begin
            s_req <= 1'b1;
            s_we  <= 1'b1;
         end
      end
   end

   assign m0_ack = (state == RESP) & ~gnt_m1;
   assign m1_ack = (state == RESP) & gnt_m1;
   assign m0_err = m0_ack & err_q;
   assign m1_err = m1_ack & err_q;
   assign hold_o = m0_req & ~m0_ack;

endmodule
